// File: rtl/wots_chain_sched.sv
// wots_chain_sched: multi-lane WOTS chain controller sharing one external F-hash core.
// Round-robin hash issue across WAIT lanes, round-robin result pop across DONE lanes.
module wots_chain_sched #(
    parameter int NUM_LANES  = 4,
    parameter int WOTS_W     = 16,
    parameter int WOTS_LOG_W = $clog2(WOTS_W),
    parameter int KEY_LEN    = 256,
    parameter int TAG_W      = 8,
    parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [KEY_LEN-1:0]    job_data,
    input  logic [WOTS_LOG_W-1:0] job_start_step,
    input  logic [WOTS_LOG_W-1:0] job_end_step,
    input  logic [255:0]          job_addr,
    input  logic [TAG_W-1:0]      job_tag,
    output logic                  hash_start,
    output logic [KEY_LEN-1:0]    hash_data_in,
    output logic [255:0]          hash_addr,
    input  logic                  hash_done,
    input  logic [KEY_LEN-1:0]    hash_data_out,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [KEY_LEN-1:0]    result_data,
    output logic [255:0]          result_addr,
    output logic [TAG_W-1:0]      result_tag,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WAIT, HASH, DONE} lane_st_t;

    lane_st_t              st     [NUM_LANES];
    lane_st_t              st_nxt [NUM_LANES];
    logic [KEY_LEN-1:0]    l_data [NUM_LANES];
    logic [255:0]          l_addr [NUM_LANES];
    logic [WOTS_LOG_W-1:0] l_step [NUM_LANES];
    logic [WOTS_LOG_W-1:0] l_end  [NUM_LANES];
    logic [TAG_W-1:0]      l_tag  [NUM_LANES];
    logic                  hash_busy;
    logic [LANE_W-1:0]     h_lane, h_ptr, r_lane, r_ptr;
    logic [NUM_LANES-1:0]  idle_v, wait_v, done_v;
    logic                  acc, acc_ok, iss, iss_ok, r_ok, r_take, done_ev, pop;
    logic [LANE_W-1:0]     acc_lane, iss_lane, r_sel, j;
    logic [WOTS_LOG_W-1:0] h_nxt;

    assign job_ready = |idle_v;
    assign busy      = ~&idle_v;
    assign acc       = job_valid && job_ready;
    assign iss       = iss_ok && !hash_busy;
    assign done_ev   = hash_busy && hash_done;
    assign pop       = result_valid && result_ready;
    assign r_take    = r_ok && (!result_valid || result_ready);
    assign h_nxt     = l_step[h_lane] + 1'b1;

    // The lane currently held in the result registers is excluded so a pop can be followed back-to-back.
    always_comb begin
        j        = '0;
        acc_ok   = 1'b0;
        acc_lane = '0;
        iss_ok   = 1'b0;
        iss_lane = '0;
        r_ok     = 1'b0;
        r_sel    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idle_v[i] = st[i] == IDLE;
            wait_v[i] = st[i] == WAIT;
            done_v[i] = st[i] == DONE && !(result_valid && r_lane == LANE_W'(i));
        end
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            j = LANE_W'(k);
            if (idle_v[j]) begin
                acc_ok   = 1'b1;
                acc_lane = j;
            end
            j = LANE_W'((int'(h_ptr) + k) % NUM_LANES);
            if (wait_v[j]) begin
                iss_ok   = 1'b1;
                iss_lane = j;
            end
            j = LANE_W'((int'(r_ptr) + k) % NUM_LANES);
            if (done_v[j]) begin
                r_ok  = 1'b1;
                r_sel = j;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            st_nxt[i] = st[i];
            if (acc && acc_ok && acc_lane == LANE_W'(i))
                st_nxt[i] = (job_start_step >= job_end_step) ? DONE : WAIT;
            if (iss && iss_lane == LANE_W'(i))
                st_nxt[i] = HASH;
            if (done_ev && h_lane == LANE_W'(i))
                st_nxt[i] = (h_nxt == l_end[i]) ? DONE : WAIT;
            if (pop && r_lane == LANE_W'(i))
                st_nxt[i] = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (acc && acc_lane == LANE_W'(i)) begin
                l_data[i] <= job_data;
                l_addr[i] <= job_addr;
                l_step[i] <= job_start_step;
                l_end[i]  <= job_end_step;
                l_tag[i]  <= job_tag;
            end else if (done_ev && h_lane == LANE_W'(i)) begin
                l_data[i]         <= hash_data_out;
                l_addr[i][63:32]  <= 32'(l_step[i]);
                l_step[i]         <= h_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) st[i] <= IDLE;
            hash_busy    <= 1'b0;
            h_lane       <= '0;
            h_ptr        <= '0;
            r_lane       <= '0;
            r_ptr        <= '0;
            hash_start   <= 1'b0;
            hash_data_in <= '0;
            hash_addr    <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_addr  <= '0;
            result_tag   <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) st[i] <= st_nxt[i];
            hash_start <= iss;
            if (iss) begin
                hash_busy    <= 1'b1;
                h_lane       <= iss_lane;
                h_ptr        <= LANE_W'((int'(iss_lane) + 1) % NUM_LANES);
                hash_data_in <= l_data[iss_lane];
                hash_addr    <= {l_addr[iss_lane][255:64], 32'(l_step[iss_lane]), l_addr[iss_lane][31:0]};
            end else if (done_ev) begin
                hash_busy <= 1'b0;
            end
            if (r_take) begin
                result_valid <= 1'b1;
                r_lane       <= r_sel;
                r_ptr        <= LANE_W'((int'(r_sel) + 1) % NUM_LANES);
                result_data  <= l_data[r_sel];
                result_addr  <= l_addr[r_sel];
                result_tag   <= l_tag[r_sel];
            end else if (pop) begin
                result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wots_chain_sched.sv
// tb_wots_chain_sched: directed bench with an F model (data+1, fixed latency) and hand-computed results.
module tb_wots_chain_sched;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         job_valid = 1'b0, job_ready;
    logic [255:0] job_data = '0;
    logic [3:0]   job_start_step = '0, job_end_step = '0;
    logic [255:0] job_addr = '0;
    logic [7:0]   job_tag = '0;
    logic         hash_start;
    logic [255:0] hash_data_in, hash_addr;
    logic         hash_done;
    logic [255:0] hash_data_out;
    logic         result_valid, result_ready = 1'b0;
    logic [255:0] result_data, result_addr;
    logic [7:0]   result_tag;
    logic         busy;

    localparam logic [255:0] A = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_cafef00d;

    int total = 0, bad = 0;
    int n_start = 0, f_cnt = 0;
    logic [255:0] f_val;
    logic [255:0] g_data [64];
    logic [255:0] g_addr [64];

    always #5 clk = ~clk;

    wots_chain_sched dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
        .job_start_step(job_start_step), .job_end_step(job_end_step),
        .job_addr(job_addr), .job_tag(job_tag),
        .hash_start(hash_start), .hash_data_in(hash_data_in), .hash_addr(hash_addr),
        .hash_done(hash_done), .hash_data_out(hash_data_out),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_addr(result_addr), .result_tag(result_tag),
        .busy(busy)
    );

    // F core model: answers each request with data+1 ten cycles later, logging every grant.
    initial begin
        hash_done = 1'b0;
        hash_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            hash_done = 1'b0;
            if (f_cnt > 0) begin
                f_cnt--;
                if (f_cnt == 0) begin
                    hash_done = 1'b1;
                    hash_data_out = f_val;
                end
            end
            if (hash_start) begin
                if (n_start < 64) begin
                    g_data[n_start] = hash_data_in;
                    g_addr[n_start] = hash_addr;
                end
                n_start++;
                f_cnt = 10;
                f_val = hash_data_in + 1;
            end
        end
    end

    function automatic logic [255:0] with_step(input logic [255:0] a, input logic [31:0] s);
        logic [255:0] r;
        r = a;
        r[63:32] = s;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [255:0] d, input logic [3:0] s, input logic [3:0] e,
                        input logic [255:0] a, input logic [7:0] t);
        int n = 0;
        @(negedge clk);
        job_valid = 1'b1;
        job_data = d;
        job_start_step = s;
        job_end_step = e;
        job_addr = a;
        job_tag = t;
        while (!job_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 256'(job_ready), 256'(1));
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic get_res(output logic [255:0] d, output logic [255:0] a, output logic [7:0] t);
        int n = 0;
        @(negedge clk);
        result_ready = 1'b1;
        while (!result_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid", 256'(result_valid), 256'(1));
        d = result_data;
        a = result_addr;
        t = result_tag;
        @(posedge clk);
        #1 result_ready = 1'b0;
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (n_start < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_starts", 256'(n_start), 256'(target));
    endtask

    logic [255:0] rd, ra, d0;
    logic [7:0]   rt, t0;
    int           n0, n;
    logic         unstable;

    initial begin
        #1;
        chk("rst job_ready", 256'(job_ready), 256'(1));
        chk("rst busy", 256'(busy), 256'(0));
        chk("rst result_valid", 256'(result_valid), 256'(0));
        chk("rst hash_start", 256'(hash_start), 256'(0));
        chk("rst hash_addr", hash_addr, 256'(0));
        chk("rst result_data", result_data, 256'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // single job, three steps
        n0 = n_start;
        push(256'(0), 4'd0, 4'd3, A, 8'hA5);
        get_res(rd, ra, rt);
        chk("t1 starts", 256'(n_start - n0), 256'(3));
        for (int i = 0; i < 3; i++)
            chk("t1 step", 256'(g_addr[n0 + i][63:32]), 256'(i));
        chk("t1 hash_addr", g_addr[n0 + 1], with_step(A, 1));
        chk("t1 data", rd, 256'(3));
        chk("t1 addr", ra, with_step(A, 2));
        chk("t1 tag", 256'(rt), 256'(8'hA5));
        @(negedge clk);
        chk("t1 busy", 256'(busy), 256'(0));

        // zero-step job
        n0 = n_start;
        push(256'hBEEF, 4'd5, 4'd5, A, 8'h11);
        n = 0;
        while (!result_valid && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("t2 latency", 256'(result_valid), 256'(1));
        get_res(rd, ra, rt);
        chk("t2 no hash", 256'(n_start - n0), 256'(0));
        chk("t2 data", rd, 256'hBEEF);
        chk("t2 addr", ra, A);
        chk("t2 tag", 256'(rt), 256'(8'h11));

        // five jobs into four lanes
        for (int i = 0; i < 4; i++) push(256'(10 + i * 8), 4'd0, 4'd1, A, 8'h30 + 8'(i));
        @(negedge clk);
        chk("t3 full", 256'(job_ready), 256'(0));
        n = 0;
        while (!result_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t3 still full", 256'(job_ready), 256'(0));
        get_res(rd, ra, rt);
        chk("t3 first tag", 256'(rt), 256'(8'h30));
        chk("t3 first data", rd, 256'(11));
        push(256'(42), 4'd0, 4'd1, A, 8'h34);
        for (int i = 1; i < 5; i++) begin
            get_res(rd, ra, rt);
            chk("t3 tag", 256'(rt), 256'(8'h30 + 8'(i)));
            chk("t3 data", rd, (i == 4) ? 256'(43) : 256'(11 + i * 8));
        end

        // four lanes, two steps each: round-robin grants
        n0 = n_start;
        for (int i = 0; i < 4; i++) push(256'(i * 16), 4'd0, 4'd2, A, 8'h40 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            get_res(rd, ra, rt);
            chk("t4 tag", 256'(rt), 256'(8'h40 + 8'(i)));
            chk("t4 data", rd, 256'(i * 16 + 2));
            chk("t4 addr", ra, with_step(A, 1));
        end
        chk("t4 starts", 256'(n_start - n0), 256'(8));
        for (int i = 0; i < 8; i++)
            chk("t4 grant", g_data[n0 + i], 256'((i % 4) * 16 + i / 4));

        // backpressure on results
        n0 = n_start;
        for (int i = 0; i < 4; i++) push(256'(i * 100), 4'd0, 4'd1, A, 8'h50 + 8'(i));
        n = 0;
        while (!result_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        d0 = result_data;
        t0 = result_tag;
        chk("t5 first tag", 256'(t0), 256'(8'h50));
        unstable = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!result_valid || result_data !== d0 || result_tag !== t0) unstable = 1'b1;
        end
        chk("t5 stable", 256'(unstable), 256'(0));
        chk("t5 hashing on", 256'(n_start - n0 >= 3), 256'(1));
        wait_starts(n0 + 4);
        repeat (14) @(negedge clk);
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5 pop valid", 256'(result_valid), 256'(1));
            chk("t5 pop tag", 256'(result_tag), 256'(8'h50 + 8'(i)));
            chk("t5 pop data", result_data, 256'(i * 100 + 1));
            @(negedge clk);
        end
        result_ready = 1'b0;
        chk("t5 drained", 256'(result_valid), 256'(0));

        // reset during an outstanding hash, late done afterwards
        n0 = n_start;
        push(256'(0), 4'd0, 4'd3, A, 8'h66);
        wait_starts(n0 + 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6 busy", 256'(busy), 256'(0));
        chk("t6 result_valid", 256'(result_valid), 256'(0));
        chk("t6 hash_start", 256'(hash_start), 256'(0));
        chk("t6 job_ready", 256'(job_ready), 256'(1));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6 late busy", 256'(busy), 256'(0));
        chk("t6 late valid", 256'(result_valid), 256'(0));
        chk("t6 late starts", 256'(n_start - n0), 256'(1));
        push(256'(5), 4'd2, 4'd4, A, 8'h77);
        get_res(rd, ra, rt);
        chk("t6 data", rd, 256'(7));
        chk("t6 addr", ra, with_step(A, 3));
        chk("t6 tag", 256'(rt), 256'(8'h77));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wots_chain_sched.md
Name: wots_chain_sched

Overview:
- Multi-lane WOTS chaining controller that runs up to NUM_LANES independent chain jobs.
- All lanes share one external F-hash core, which is exposed as a start/done port.
- Each job is described by input value, start_step, end_step, hash address and tag. The block iterates F from start_step to end_step-1 and writes the current step into the address hash field.
- Intended as the successor of the single-chain generator inside WOTS keygen, sign and verify, so that multiple chains keep one hash core busy.

Parameters:
NUM_LANES, 4, number of concurrent chain jobs (≥1).
WOTS_W, 16, Winternitz parameter.
WOTS_LOG_W, CLOG2(WOTS_W), step field width.
KEY_LEN, 256, chain value width.
TAG_W, 8, caller job tag width.
LANE_W, CLOG2(NUM_LANES) (min 1), lane index width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
job_valid  in  1  job offered
job_ready  out  1  a lane is free
job_data  in  KEY_LEN  chain input value
job_start_step  in  WOTS_LOG_W  first step
job_end_step  in  WOTS_LOG_W  exclusive last step
job_addr  in  256  XMSS address, 8x32-bit words, word0 at [255:224]
job_tag  in  TAG_W  returned with result
hash_start  out  1  one-cycle request pulse to F core
hash_data_in  out  KEY_LEN  current chain value of granted lane
hash_addr  out  256  job address with bits [63:32] = zero-extended current step
hash_done  in  1  one-cycle F completion
hash_data_out  in  KEY_LEN  F result
result_valid  out  1  finished chain available
result_ready  in  1  consumer accepts
result_data  out  KEY_LEN  chain output
result_addr  out  256  address with hash field = last step used (unchanged if zero steps)
result_tag  out  TAG_W  job tag
busy  out  1  any lane not IDLE

Behaviour:
- Reset (async, active-high): all lanes IDLE, no outstanding hash, RR pointers = 0. All outputs 0 except job_ready = 1.
- Per-lane FSM: IDLE -> WAIT (needs hash) or DONE (zero steps) -> HASH -> WAIT/DONE -> IDLE.
- Accept: on job_valid & job_ready, the job is loaded into the lowest-index IDLE lane. job_ready = OR of IDLE lanes, computed combinationally from registered state.
- Zero steps: if job_start_step ≥ job_end_step, the lane goes directly to DONE with data and addr unchanged; no hash is issued.
- Otherwise the lane enters WAIT with step = job_start_step.
- Hash issue:
  - Only one hash is outstanding at a time.
  - When no hash is outstanding and some lane is in WAIT, a round-robin arbiter starts searching at the lane after the last grant. The winner moves to HASH.
  - hash_start pulses for exactly 1 cycle. hash_data_in and hash_addr are registered and held stable until hash_done.
  - Earliest hash_start is the cycle after job acceptance.
- On hash_done: the granted lane's value becomes hash_data_out, its address hash field becomes step, and step increments. If step+1 == end_step the lane goes to DONE, else back to WAIT.
- The arbiter can issue the next hash in the cycle after hash_done. That next hash may be to the same lane if it is the only one waiting.
- hash_done with no outstanding request is ignored.
- Result output:
  - Round-robin over DONE lanes using its own pointer. The selected lane is latched into output registers.
  - result_valid/data/addr/tag are held stable until result_ready, then the lane returns to IDLE.
  - Next result_valid earliest the following cycle.
  - A lane freed in cycle t may accept a job in cycle t+1.
- Step arithmetic: step is WOTS_LOG_W bits and never wraps, because end_step ≤ WOTS_W-1. Address words other than [63:32] pass through unmodified.
- Simultaneous events: job accept, hash_done and result pop in the same cycle are all honoured. A lane may go DONE in the same cycle another lane is popped.
- Reset mid-operation: all jobs are discarded and the outstanding hash is forgotten. A late hash_done after reset is ignored.

Test Plan:
- Single job, data=0, steps 0->3, bench F model = data+1 with 10-cycle latency -> exactly 3 hash_start pulses with hash_addr[63:32]=0,1,2. result_data=3, result_addr[63:32]=2, tag echoed.
- Zero-step job (start=5, end=5) -> no hash_start; result_data=job_data, result_addr=job_addr, within 3 cycles.
- 5 jobs back-to-back with NUM_LANES=4 -> job_ready low after 4th accept. 5th accepted only after first result pop.
- 4 lanes each steps 0->2 -> hash grants in lane order 0,1,2,3,0,1,2,3. Results returned with correct tags.
- result_ready held low 20 cycles -> result outputs stable. Other lanes continue hashing. Pops proceed one per cycle once ready.
- Assert reset during a hash, then pulse hash_done -> busy=0, result_valid=0, hash_start=0, job_ready=1. New job afterwards completes correctly.
